// File: rtl/pong_ball_engine.sv
// Pong ball-motion and scoring engine: advances the ball on each slow tick, resolves
// wall/paddle bounces and misses, keeps score and sequences serve/point/game-over.
module pong_ball_engine #(
  parameter int FIELD_W        = 640,
  parameter int FIELD_H        = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int STEP           = 2,
  parameter int HOLD_TICKS     = 60,
  parameter int WIN_SCORE      = 7
) (
  input  logic       fastclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       serve,
  input  logic [8:0] left_y,
  input  logic [8:0] right_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       hit,
  output logic       point_l,
  output logic       point_r,
  output logic       in_play,
  output logic       game_over
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_POINT, S_OVER} state_t;

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  // Compare-domain constants carry one extra bit so sums and differences never wrap.
  localparam logic [10:0] FW_X    = 11'(FIELD_W);
  localparam logic [10:0] BS_X    = 11'(BALL_SIZE);
  localparam logic [10:0] STEP_X  = 11'(STEP);
  localparam logic [10:0] LFACE_X = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] RFACE_X = 11'(RIGHT_PADDLE_X);
  localparam logic [9:0]  FH_Y    = 10'(FIELD_H);
  localparam logic [9:0]  BS_Y    = 10'(BALL_SIZE);
  localparam logic [9:0]  STEP_Y  = 10'(STEP);
  localparam logic [9:0]  PH_Y    = 10'(PADDLE_H);

  localparam logic [9:0] CENTER_X   = 10'((FIELD_W - BALL_SIZE) / 2);
  localparam logic [9:0] EDGE_R_X   = 10'(FIELD_W - BALL_SIZE);
  localparam logic [9:0] LHIT_X     = 10'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [9:0] RHIT_X     = 10'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [9:0] STEP_OUT_X = 10'(STEP);
  localparam logic [8:0] CENTER_Y   = 9'((FIELD_H - BALL_SIZE) / 2);
  localparam logic [8:0] EDGE_B_Y   = 9'(FIELD_H - BALL_SIZE);
  localparam logic [8:0] STEP_OUT_Y = 9'(STEP);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            state_q,     state_d;
  logic [9:0]        ball_x_q,    ball_x_d;
  logic [8:0]        ball_y_q,    ball_y_d;
  logic              dir_x_q,     dir_x_d;     // 1 = moving right
  logic              dir_y_q,     dir_y_d;     // 1 = moving down
  logic [3:0]        score_l_q,   score_l_d;
  logic [3:0]        score_r_q,   score_r_d;
  logic [HOLD_W-1:0] hold_q,      hold_d;
  logic              hit_q,       hit_d;
  logic              point_l_q,   point_l_d;
  logic              point_r_q,   point_r_d;
  logic              in_play_q,   in_play_d;
  logic              game_over_q, game_over_d;

  logic [10:0] x_w;
  logic [9:0]  y_w, ly_w, ry_w;
  logic        ovl_l, ovl_r;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; that is what keeps the synthesiser from inferring latches.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    hold_d      = hold_q;
    hit_d       = 1'b0;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;

    x_w   = {1'b0, ball_x_q};
    y_w   = {1'b0, ball_y_q};
    ly_w  = {1'b0, left_y};
    ry_w  = {1'b0, right_y};
    ovl_l = (y_w + BS_Y > ly_w) && (y_w < ly_w + PH_Y);
    ovl_r = (y_w + BS_Y > ry_w) && (y_w < ry_w + PH_Y);

    case (state_q)
      S_IDLE: begin
        if (serve) state_d = S_PLAY;
      end

      S_PLAY: begin
        if (tick) begin
          if (!dir_y_q) begin
            if (y_w < STEP_Y) begin
              ball_y_d = '0;
              dir_y_d  = 1'b1;
            end else begin
              ball_y_d = ball_y_q - STEP_OUT_Y;
            end
          end else if (y_w + BS_Y + STEP_Y > FH_Y) begin
            ball_y_d = EDGE_B_Y;
            dir_y_d  = 1'b0;
          end else begin
            ball_y_d = ball_y_q + STEP_OUT_Y;
          end

          // Paddle windows start at the face, so a ball already past it is never caught.
          if (!dir_x_q) begin
            if (x_w >= LFACE_X && x_w <= LFACE_X + STEP_X && ovl_l) begin
              ball_x_d = LHIT_X;
              dir_x_d  = 1'b1;
              hit_d    = 1'b1;
            end else if (x_w < STEP_X) begin
              ball_x_d  = '0;
              score_r_d = (score_r_q < WIN) ? score_r_q + 4'd1 : score_r_q;
              point_r_d = 1'b1;
              dir_x_d   = 1'b0;
              state_d   = S_POINT;
            end else begin
              ball_x_d = ball_x_q - STEP_OUT_X;
            end
          end else begin
            if (x_w + BS_X <= RFACE_X && x_w + BS_X + STEP_X >= RFACE_X && ovl_r) begin
              ball_x_d = RHIT_X;
              dir_x_d  = 1'b0;
              hit_d    = 1'b1;
            end else if (x_w + BS_X + STEP_X > FW_X) begin
              ball_x_d  = EDGE_R_X;
              score_l_d = (score_l_q < WIN) ? score_l_q + 4'd1 : score_l_q;
              point_l_d = 1'b1;
              dir_x_d   = 1'b1;
              state_d   = S_POINT;
            end else begin
              ball_x_d = ball_x_q + STEP_OUT_X;
            end
          end
        end
      end

      S_POINT: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d   = '0;
            ball_x_d = CENTER_X;
            ball_y_d = CENTER_Y;
            state_d  = (score_l_q == WIN || score_r_q == WIN) ? S_OVER : S_IDLE;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
      end

      S_OVER: begin
        if (serve) begin
          score_l_d = '0;
          score_r_d = '0;
          dir_x_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_play_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset sits in the
  // sensitivity list so it takes effect without waiting for a clock edge.
  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ball_x_q    <= CENTER_X;
      ball_y_q    <= CENTER_Y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      hold_q      <= '0;
      hit_q       <= 1'b0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      in_play_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hold_q      <= hold_d;
      hit_q       <= hit_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      in_play_q   <= in_play_d;
      game_over_q <= game_over_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign hit       = hit_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign in_play   = in_play_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: hand-computed ball trajectories, bounces,
// misses, hold timing, game-over and asynchronous reset behaviour.
module tb_pong_ball_engine;

  logic       fastclk = 1'b0;
  logic       reset   = 1'b1;
  logic       tick    = 1'b0;
  logic       serve   = 1'b0;
  logic [8:0] left_y  = 9'd0;
  logic [8:0] right_y = 9'd0;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l, score_r;
  logic       hit, point_l, point_r, in_play, game_over;

  int tests_run    = 0;
  int tests_failed = 0;
  int hit_cnt, pl_cnt, pr_cnt, stale_cnt;

  always #5 fastclk = ~fastclk;

  pong_ball_engine dut (
    .fastclk  (fastclk),
    .reset    (reset),
    .tick     (tick),
    .serve    (serve),
    .left_y   (left_y),
    .right_y  (right_y),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .score_l  (score_l),
    .score_r  (score_r),
    .hit      (hit),
    .point_l  (point_l),
    .point_r  (point_r),
    .in_play  (in_play),
    .game_over(game_over)
  );

  // One tick strobe; pulses are tallied in the cycle after the strobe and must be gone a cycle later.
  task automatic step_tick();
    @(negedge fastclk);
    if (hit || point_l || point_r) stale_cnt++;
    tick = 1'b1;
    @(negedge fastclk);
    tick = 1'b0;
    hit_cnt += int'(hit);
    pl_cnt  += int'(point_l);
    pr_cnt  += int'(point_r);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) step_tick();
  endtask

  task automatic do_serve();
    @(negedge fastclk);
    serve = 1'b1;
    @(negedge fastclk);
    serve = 1'b0;
  endtask

  task automatic apply_reset();
    tick  = 1'b0;
    serve = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge fastclk);
    reset = 1'b0;
    hit_cnt = 0; pl_cnt = 0; pr_cnt = 0; stale_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (ball_x !== 10'd316) begin tests_failed++; $display("FAIL reset_x: got %0d want 316", ball_x); end
    tests_run++; if (ball_y !== 9'd236) begin tests_failed++; $display("FAIL reset_y: got %0d want 236", ball_y); end
    tests_run++; if (score_l !== 4'd0 || score_r !== 4'd0) begin tests_failed++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score_l, score_r); end
    tests_run++; if (in_play !== 1'b0 || game_over !== 1'b0) begin tests_failed++; $display("FAIL reset_state: in_play=%0b game_over=%0b want 0/0", in_play, game_over); end
    @(negedge fastclk);
    serve = 1'b1; tick = 1'b1;
    @(negedge fastclk);
    serve = 1'b0; tick = 1'b0;
    tests_run++; if (in_play !== 1'b1) begin tests_failed++; $display("FAIL serve_in_play: got %0b want 1", in_play); end
    tests_run++; if (ball_x !== 10'd316 || ball_y !== 9'd236) begin tests_failed++; $display("FAIL serve_tick_ignored: got (%0d,%0d) want (316,236)", ball_x, ball_y); end
    step_tick();
    tests_run++; if (ball_x !== 10'd318 || ball_y !== 9'd238) begin tests_failed++; $display("FAIL first_move: got (%0d,%0d) want (318,238)", ball_x, ball_y); end
  endtask

  task automatic test_wall_and_right_hit();
    apply_reset();
    right_y = 9'd400;
    do_serve();
    run_ticks(118);
    tests_run++; if (ball_x !== 10'd552 || ball_y !== 9'd472) begin tests_failed++; $display("FAIL tick118: got (%0d,%0d) want (552,472)", ball_x, ball_y); end
    step_tick();
    tests_run++; if (ball_y !== 9'd472) begin tests_failed++; $display("FAIL bottom_clamp: got %0d want 472", ball_y); end
    step_tick();
    tests_run++; if (ball_y !== 9'd470) begin tests_failed++; $display("FAIL bottom_bounce: got %0d want 470", ball_y); end
    run_ticks(25);
    tests_run++; if (ball_x !== 10'd606 || hit_cnt != 0) begin tests_failed++; $display("FAIL pre_hit: x=%0d hits=%0d want 606/0", ball_x, hit_cnt); end
    step_tick();
    tests_run++; if (ball_x !== 10'd608 || hit_cnt != 1) begin tests_failed++; $display("FAIL right_hit: x=%0d hits=%0d want 608/1", ball_x, hit_cnt); end
    step_tick();
    tests_run++; if (ball_x !== 10'd606 || hit_cnt != 1 || stale_cnt != 0) begin tests_failed++; $display("FAIL after_hit: x=%0d hits=%0d stale=%0d want 606/1/0", ball_x, hit_cnt, stale_cnt); end
  endtask

  task automatic test_miss_right();
    apply_reset();
    right_y = 9'd0;
    do_serve();
    run_ticks(158);
    tests_run++; if (ball_x !== 10'd632 || pl_cnt != 0 || in_play !== 1'b1) begin tests_failed++; $display("FAIL pre_miss: x=%0d points=%0d in_play=%0b want 632/0/1", ball_x, pl_cnt, in_play); end
    step_tick();
    tests_run++; if (ball_x !== 10'd632 || ball_y !== 9'd392) begin tests_failed++; $display("FAIL miss_pos: got (%0d,%0d) want (632,392)", ball_x, ball_y); end
    tests_run++; if (pl_cnt != 1 || score_l !== 4'd1 || score_r !== 4'd0 || hit_cnt != 0) begin tests_failed++; $display("FAIL miss_score: points=%0d score=%0d/%0d hits=%0d want 1,1/0,0", pl_cnt, score_l, score_r, hit_cnt); end
    tests_run++; if (in_play !== 1'b0) begin tests_failed++; $display("FAIL miss_state: in_play=%0b want 0", in_play); end
    run_ticks(30);
    do_serve();
    tests_run++; if (in_play !== 1'b0) begin tests_failed++; $display("FAIL serve_in_point: in_play=%0b want 0", in_play); end
    run_ticks(29);
    tests_run++; if (ball_x !== 10'd632 || pl_cnt != 1 || stale_cnt != 0) begin tests_failed++; $display("FAIL hold_59: x=%0d points=%0d stale=%0d want 632/1/0", ball_x, pl_cnt, stale_cnt); end
    step_tick();
    tests_run++; if (ball_x !== 10'd316 || ball_y !== 9'd236 || in_play !== 1'b0 || game_over !== 1'b0) begin tests_failed++; $display("FAIL hold_done: (%0d,%0d) in_play=%0b over=%0b want (316,236) 0 0", ball_x, ball_y, in_play, game_over); end
    do_serve();
    step_tick();
    tests_run++; if (ball_x !== 10'd318 || ball_y !== 9'd234) begin tests_failed++; $display("FAIL reserve_dir: got (%0d,%0d) want (318,234)", ball_x, ball_y); end
  endtask

  task automatic test_game_over();
    apply_reset();
    right_y = 9'd480;
    for (int r = 1; r <= 7; r++) begin
      do_serve();
      run_ticks(159);
      tests_run++; if (score_l !== 4'(r) || pl_cnt != r) begin tests_failed++; $display("FAIL rally_%0d: score=%0d points=%0d want %0d", r, score_l, pl_cnt, r); end
      if (r < 7) begin
        run_ticks(60);
        tests_run++; if (in_play !== 1'b0 || game_over !== 1'b0) begin tests_failed++; $display("FAIL rally_%0d_idle: in_play=%0b over=%0b want 0/0", r, in_play, game_over); end
      end
    end
    run_ticks(59);
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL over_early: game_over=%0b want 0", game_over); end
    step_tick();
    tests_run++; if (game_over !== 1'b1 || score_l !== 4'd7 || ball_x !== 10'd316 || ball_y !== 9'd236) begin tests_failed++; $display("FAIL over_enter: over=%0b score=%0d (%0d,%0d) want 1 7 (316,236)", game_over, score_l, ball_x, ball_y); end
    step_tick();
    tests_run++; if (game_over !== 1'b1 || score_l !== 4'd7) begin tests_failed++; $display("FAIL over_hold: over=%0b score=%0d want 1/7", game_over, score_l); end
    do_serve();
    tests_run++; if (game_over !== 1'b0 || in_play !== 1'b0 || score_l !== 4'd0 || score_r !== 4'd0) begin tests_failed++; $display("FAIL over_clear: over=%0b in_play=%0b scores=%0d/%0d want 0 0 0/0", game_over, in_play, score_l, score_r); end
    step_tick();
    tests_run++; if (ball_x !== 10'd316) begin tests_failed++; $display("FAIL over_serve_not_play: x=%0d want 316", ball_x); end
    do_serve();
    step_tick();
    tests_run++; if (ball_x !== 10'd318) begin tests_failed++; $display("FAIL new_game_dir: x=%0d want 318", ball_x); end
  endtask

  task automatic test_left_side();
    apply_reset();
    right_y = 9'd400;
    left_y  = 9'd158;
    do_serve();
    run_ticks(437);
    tests_run++; if (ball_x !== 10'd26 || ball_y !== 9'd162 || hit_cnt != 1) begin tests_failed++; $display("FAIL pre_left: (%0d,%0d) hits=%0d want (26,162) 1", ball_x, ball_y, hit_cnt); end
    step_tick();
    tests_run++; if (ball_x !== 10'd24 || ball_y !== 9'd164 || hit_cnt != 2) begin tests_failed++; $display("FAIL left_hit: (%0d,%0d) hits=%0d want (24,164) 2", ball_x, ball_y, hit_cnt); end
    step_tick();
    tests_run++; if (ball_x !== 10'd26 || hit_cnt != 2) begin tests_failed++; $display("FAIL after_left: x=%0d hits=%0d want 26/2", ball_x, hit_cnt); end

    apply_reset();
    right_y = 9'd400;
    left_y  = 9'd300;
    do_serve();
    run_ticks(450);
    tests_run++; if (ball_x !== 10'd0 || pr_cnt != 0 || in_play !== 1'b1 || hit_cnt != 1) begin tests_failed++; $display("FAIL pre_miss_left: x=%0d points=%0d in_play=%0b hits=%0d want 0 0 1 1", ball_x, pr_cnt, in_play, hit_cnt); end
    step_tick();
    tests_run++; if (ball_x !== 10'd0 || pr_cnt != 1 || score_r !== 4'd1 || score_l !== 4'd0 || in_play !== 1'b0) begin tests_failed++; $display("FAIL miss_left: x=%0d points=%0d scores=%0d/%0d in_play=%0b want 0 1 0/1 0", ball_x, pr_cnt, score_l, score_r, in_play); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    right_y = 9'd0;
    left_y  = 9'd0;
    do_serve();
    run_ticks(50);
    tests_run++; if (ball_x !== 10'd416) begin tests_failed++; $display("FAIL mid_play_pos: x=%0d want 416", ball_x); end
    @(posedge fastclk);
    #2 reset = 1'b1;
    #1;
    tests_run++; if (ball_x !== 10'd316 || ball_y !== 9'd236 || in_play !== 1'b0 || hit || point_l || point_r) begin tests_failed++; $display("FAIL async_reset_play: (%0d,%0d) in_play=%0b pulses=%0b%0b%0b want (316,236) 0 000", ball_x, ball_y, in_play, hit, point_l, point_r); end
    repeat (3) begin
      @(negedge fastclk); tick = 1'b1; serve = 1'b1;
      @(negedge fastclk); tick = 1'b0; serve = 1'b0;
    end
    tests_run++; if (ball_x !== 10'd316 || in_play !== 1'b0) begin tests_failed++; $display("FAIL tick_in_reset: x=%0d in_play=%0b want 316/0", ball_x, in_play); end
    reset = 1'b0;
    step_tick();
    tests_run++; if (ball_x !== 10'd316 || in_play !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: x=%0d in_play=%0b want 316/0", ball_x, in_play); end

    do_serve();
    run_ticks(169);
    tests_run++; if (score_l !== 4'd1 || ball_x !== 10'd632) begin tests_failed++; $display("FAIL mid_point_setup: score=%0d x=%0d want 1/632", score_l, ball_x); end
    @(posedge fastclk);
    #2 reset = 1'b1;
    #1;
    tests_run++; if (score_l !== 4'd0 || ball_x !== 10'd316 || ball_y !== 9'd236) begin tests_failed++; $display("FAIL async_reset_point: score=%0d (%0d,%0d) want 0 (316,236)", score_l, ball_x, ball_y); end
    @(negedge fastclk);
    reset = 1'b0;
  endtask

  initial begin
    hit_cnt = 0; pl_cnt = 0; pr_cnt = 0; stale_cnt = 0;
    test_reset();
    test_wall_and_right_hit();
    test_miss_right();
    test_game_over();
    test_left_side();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
